// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Overflow handling is selected by the OVERFLOW_DASH_EN macro.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4;
  localparam int BIN_W      = 14;

  localparam logic [BCD_W-1:0] BCD_DASH = 4'd10;
  localparam logic [BIN_W-1:0] MAX_DISP = 14'd9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } scan_state_t;

  // Index 3 is the thousands digit, index 0 the units digit.
  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd4_t;

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  function automatic bcd4_t dabble_adjust(input bcd4_t s);
    bcd4_t r;
    r = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s[i] >= 4'd5) r[i] = s[i] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (one double-dabble step per cycle).
// OVERFLOW_DASH_EN selects dash output for values above 9999; otherwise they are clamped.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output bcd4_t            result
);

  scan_state_t      state;
  scan_state_t      next_state;
  logic [3:0]       iter;
  bcd4_t            scratch;
  logic [BIN_W-1:0] bin_sr;
  logic [BIN_W-1:0] captured;
  logic [29:0]      shifted;

  assign shifted = {dabble_adjust(scratch), bin_sr} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (iter == 4'd13) next_state = COMMIT;
      end
      COMMIT: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch <= '0;
      bin_sr  <= '0;
      iter    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= '0;
            bin_sr  <= captured;
            iter    <= '0;
          end
        end
        SHIFT: begin
          {scratch, bin_sr} <= shifted;
          iter              <= iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef OVERFLOW_DASH_EN
  logic ovf;

  assign captured = bin;

  // The flag is frozen at capture so a changing input cannot affect an in-flight conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf <= 1'b0;
    else if (state == IDLE && start) ovf <= (bin > MAX_DISP);
  end

  assign result = ovf ? {NUM_DIGITS{BCD_DASH}} : scratch;
`else
  assign captured = (bin > MAX_DISP) ? MAX_DISP : bin;
  assign result   = scratch;
`endif

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan driver: converts a loaded binary value to BCD and multiplexes the digits.
// Build option OVERFLOW_DASH_EN shows "----" for values above 9999 instead of clamping.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic [1:0]       en,
  output logic [BCD_W-1:0] bcd,
  output logic             frame_tick
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0] prescale;
  logic             slot_end;
  logic             conv_done;
  bcd4_t            conv_result;
  bcd4_t            digits;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (load),
    .bin    (value),
    .busy   (busy),
    .done   (conv_done),
    .result (conv_result)
  );

  // Digits only change on the commit edge, so the display never shows a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         digits <= '0;
    else if (conv_done) digits <= conv_result;
  end

  assign slot_end = (prescale == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale   <= '0;
      en         <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= slot_end && (en == 2'd3);
      if (slot_end) begin
        prescale <= '0;
        en       <= en + 2'd1;
      end else begin
        prescale <= prescale + PRE_W'(1);
      end
    end
  end

  // en=0 selects the thousands digit, which lives in the top nibble.
  assign bcd = digits[~en];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a decimal-arithmetic reference model.
// Compile with +define+OVERFLOW_DASH_EN to check the dash overflow variant.
module tb_seg_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic        busy;
  logic [1:0]  en;
  logic [3:0]  bcd;
  logic        frame_tick;

  int n_checks = 0;
  int n_pass = 0;
  int t = 0;
  int exp_dig[4];

  seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .busy       (busy),
    .en         (en),
    .bcd        (bcd),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Count of rising edges since reset was released; the whole scan model derives from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  function automatic int exp_en();
    return (t / DIV) % 4;
  endfunction

  function automatic logic exp_ft();
    return (t != 0) && (t % (4 * DIV) == 0);
  endfunction

  task automatic set_model(input int v);
    int x;
    x = v;
`ifdef OVERFLOW_DASH_EN
    if (v > 9999) begin
      for (int i = 0; i < 4; i++) exp_dig[i] = 10;
      return;
    end
`else
    if (v > 9999) x = 9999;
`endif
    exp_dig[0] = (x / 1000) % 10;
    exp_dig[1] = (x / 100) % 10;
    exp_dig[2] = (x / 10) % 10;
    exp_dig[3] = x % 10;
  endtask

  task automatic test_reset();
    set_model(0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, en, bcd, frame_tick} !== 8'h00)
      $display("[TB] FAIL reset_outputs: got busy=%b en=%0d bcd=%0d ft=%b, want all 0", busy, en, bcd, frame_tick);
    else n_pass++;
    rst_n = 1'b1;
    for (int j = 0; j < 34; j++) begin
      @(negedge clk);
      n_checks++;
      if (en !== 2'(exp_en()) || bcd !== 4'd0 || frame_tick !== exp_ft() || busy !== 1'b0)
        $display("[TB] FAIL idle_scan t=%0d: got en=%0d bcd=%0d ft=%b busy=%b, want en=%0d bcd=0 ft=%b busy=0",
                 t, en, bcd, frame_tick, busy, exp_en(), exp_ft());
      else n_pass++;
    end
  endtask

  // Loads v, optionally pulses a stray load (junk_v) at busy cycle junk_at, then checks a full frame.
  task automatic test_conversion(input int v, input int junk_at, input int junk_v);
    int  cnt;
    bit  done;
    cnt  = 0;
    done = 0;
    @(negedge clk);
    value = 14'(v);
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (busy === 1'b1) begin
        cnt++;
        n_checks++;
        if (bcd !== 4'(exp_dig[exp_en()]))
          $display("[TB] FAIL hold_prev v=%0d cyc=%0d: got bcd=%0d, want %0d", v, cnt, bcd, exp_dig[exp_en()]);
        else n_pass++;
        if (cnt == junk_at) begin
          value = 14'(junk_v);
          load  = 1'b1;
        end
      end else begin
        done = 1;
      end
    end
    n_checks++;
    if (cnt != 15 || !done)
      $display("[TB] FAIL busy_len v=%0d: got %0d cycles, want 15", v, cnt);
    else n_pass++;
    set_model(v);
    for (int j = 0; j < 17; j++) begin
      if (j > 0) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || en !== 2'(exp_en()) || bcd !== 4'(exp_dig[exp_en()]) || frame_tick !== exp_ft())
        $display("[TB] FAIL frame v=%0d t=%0d: got busy=%b en=%0d bcd=%0d ft=%b, want busy=0 en=%0d bcd=%0d ft=%b",
                 v, t, busy, en, bcd, frame_tick, exp_en(), exp_dig[exp_en()], exp_ft());
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    test_conversion(1234, 0, 0);
    test_conversion(8, 0, 0);
    test_conversion(1999, 0, 0);
  endtask

  task automatic test_back_to_back();
    test_conversion(9999, 5, 5555);
    test_conversion(0, 15, 5555);
    test_conversion(7, 0, 0);
  endtask

  task automatic test_overflow();
    test_conversion(12000, 0, 0);
    test_conversion(16383, 0, 0);
    test_conversion(10000, 0, 0);
  endtask

  task automatic test_reset_mid();
    test_conversion(42, 0, 0);
    @(negedge clk);
    value = 14'd4321;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    set_model(0);
    #1;
    n_checks++;
    if ({busy, en, bcd, frame_tick} !== 8'h00)
      $display("[TB] FAIL reset_mid: got busy=%b en=%0d bcd=%0d ft=%b, want all 0", busy, en, bcd, frame_tick);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || en !== 2'(exp_en()) || bcd !== 4'(exp_dig[exp_en()]) || frame_tick !== exp_ft())
        $display("[TB] FAIL after_reset t=%0d: got busy=%b en=%0d bcd=%0d ft=%b, want busy=0 en=%0d bcd=0 ft=%b",
                 t, busy, en, bcd, frame_tick, exp_en(), exp_ft());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? int'($urandom_range(9999, 0)) : int'($urandom_range(16383, 0));
      test_conversion(v, (i % 3 == 0) ? int'($urandom_range(15, 1)) : 0, int'($urandom_range(16383, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
